// File: rtl/zeroriscy_dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | zeroriscy_dmem_responder: word memory slave with programmable gnt stall  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module zeroriscy_dmem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int GNT_STALL = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic [15:0] txn_cnt_o
);

  localparam int         AW           = $clog2(MEM_WORDS);
  localparam logic [3:0] C_STALL_LOAD = (GNT_STALL > 0) ? 4'(GNT_STALL - 1) : 4'd0;
  localparam logic       C_NO_STALL   = (GNT_STALL == 0);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        rvalid_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;
  logic [15:0] txn_cnt_q;
  logic [31:0] mem_q [MEM_WORDS];

  logic          w_gnt;
  logic          w_oor;
  logic [AW-1:0] w_idx;
  logic          w_unused_addr;

  assign w_idx         = data_addr_i[AW+1:2];
  assign w_oor         = |data_addr_i[31:AW+2];
  assign w_unused_addr = ^data_addr_i[1:0];

  // Grant is combinational so a zero-stall slave accepts in the request cycle.
  always_comb begin
    w_gnt = 1'b0;
    if (!rst && data_req_i) begin
      if (state_q == IDLE) w_gnt = C_NO_STALL;
      else                 w_gnt = (cnt_q == 4'd0);
    end
  end

  always_comb begin
    rdata_d = '0;
    if (w_gnt && !data_we_i && !w_oor) rdata_d = mem_q[w_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      txn_cnt_q <= '0;
    end else begin
      rvalid_q <= w_gnt;
      err_q    <= w_gnt & w_oor;
      rdata_q  <= rdata_d;
      if (w_gnt) txn_cnt_q <= txn_cnt_q + 16'd1;
      case (state_q)
        IDLE: begin
          if (data_req_i && !C_NO_STALL) begin
            state_q <= STALL;
            cnt_q   <= C_STALL_LOAD;
          end
        end
        STALL: begin
          if (!data_req_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == 4'd0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Storage is deliberately outside the reset domain so contents survive rst.
  always_ff @(posedge clk) begin
    if (w_gnt && data_we_i && !w_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) mem_q[w_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
  end

  assign data_gnt_o    = w_gnt;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;
  assign txn_cnt_o     = txn_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_zeroriscy_dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_zeroriscy_dmem_responder: scoreboard bench, zero-stall and 3-stall DUT |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_zeroriscy_dmem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req3, we_s;
  logic [31:0] addr_s, wdata_s;
  logic [3:0]  be_s;
  logic        gnt0, rvalid0, err0, gnt3, rvalid3, err3;
  logic [31:0] rdata0, rdata3;
  logic [15:0] txn0, txn3;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [15:0] exp0    = '0;
  logic [15:0] exp3    = '0;
  resp_t       q0[$];
  resp_t       q3[$];
  logic [31:0] m0 [1024];
  logic [31:0] m3 [1024];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  zeroriscy_dmem_responder #(.MEM_WORDS(1024), .GNT_STALL(0)) u_dut0 (
    .clk(clk), .rst(rst), .data_req_i(req0), .data_addr_i(addr_s), .data_we_i(we_s),
    .data_be_i(be_s), .data_wdata_i(wdata_s), .data_gnt_o(gnt0), .data_rvalid_o(rvalid0),
    .data_rdata_o(rdata0), .data_err_o(err0), .txn_cnt_o(txn0)
  );

  zeroriscy_dmem_responder #(.MEM_WORDS(1024), .GNT_STALL(3)) u_dut3 (
    .clk(clk), .rst(rst), .data_req_i(req3), .data_addr_i(addr_s), .data_we_i(we_s),
    .data_be_i(be_s), .data_wdata_i(wdata_s), .data_gnt_o(gnt3), .data_rvalid_o(rvalid3),
    .data_rdata_o(rdata3), .data_err_o(err3), .txn_cnt_o(txn3)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drives one request and pushes its expected response once the grant is seen.
  task automatic issue(input bit sel, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    resp_t       r;
    logic [29:0] idx;
    logic [31:0] cur;
    we_s = we; addr_s = addr; be_s = be; wdata_s = wd;
    if (sel) req3 = 1'b1; else req0 = 1'b1;
    for (int i = 0; i < (sel ? 3 : 0); i++) begin
      @(negedge clk);
      chk($sformatf("gnt%0d_stall", sel ? 3 : 0), 32'(sel ? gnt3 : gnt0), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk($sformatf("gnt%0d", sel ? 3 : 0), 32'(sel ? gnt3 : gnt0), 32'd1);
    idx     = addr[31:2];
    r.cyc   = cyc + 1;
    r.rdata = '0;
    r.err   = 1'b0;
    if (idx >= 30'd1024) begin
      r.err = 1'b1;
    end else begin
      cur = sel ? m3[idx[9:0]] : m0[idx[9:0]];
      if (we) begin
        for (int b = 0; b < 4; b++) if (be[b]) cur[8*b +: 8] = wd[8*b +: 8];
        if (sel) m3[idx[9:0]] = cur; else m0[idx[9:0]] = cur;
      end else begin
        r.rdata = cur;
      end
    end
    if (sel) begin q3.push_back(r); exp3++; end
    else     begin q0.push_back(r); exp0++; end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin : mon0
    resp_t r;
    if (rvalid0) begin
      if (q0.size() == 0) chk("rvalid0_spurious", 32'd1, 32'd0);
      else begin
        r = q0.pop_front();
        chk("rvalid0_cycle", 32'(cyc), 32'(r.cyc));
        chk("rdata0", rdata0, r.rdata);
        chk("err0", 32'(err0), 32'(r.err));
      end
    end else begin
      chk("idle0_zero", rdata0 | 32'(err0), 32'd0);
      if (q0.size() > 0 && q0[0].cyc <= cyc) begin
        chk("rvalid0_missing", 32'd0, 32'd1);
        void'(q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin : mon3
    resp_t r;
    if (rvalid3) begin
      if (q3.size() == 0) chk("rvalid3_spurious", 32'd1, 32'd0);
      else begin
        r = q3.pop_front();
        chk("rvalid3_cycle", 32'(cyc), 32'(r.cyc));
        chk("rdata3", rdata3, r.rdata);
        chk("err3", 32'(err3), 32'(r.err));
      end
    end else begin
      chk("idle3_zero", rdata3 | 32'(err3), 32'd0);
      if (q3.size() > 0 && q3[0].cyc <= cyc) begin
        chk("rvalid3_missing", 32'd0, 32'd1);
        void'(q3.pop_front());
      end
    end
  end

  task automatic enter_reset();
    rst = 1'b1;
    q0.delete(); q3.delete();
    exp0 = '0; exp3 = '0;
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b1; req3 = 1'b1;
    we_s = 1'b0; addr_s = '0; be_s = '0; wdata_s = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt3", 32'(gnt3), 32'd0);
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_txn0", 32'(txn0), 32'd0);
    chk("rst_txn3", 32'(txn3), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req0 = 1'b0; req3 = 1'b0;
    @(posedge clk); #1;

    // Back-to-back write then read of the same word.
    issue(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    issue(0, 1'b0, 32'h10, 4'h0, 32'h0);
    req0 = 1'b0;
    @(posedge clk); #1;
    chk("txn0_two", 32'(txn0), 32'd2);

    // Byte-lane merge.
    issue(0, 1'b1, 32'h20, 4'hF, 32'h11223344);
    issue(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
    issue(0, 1'b0, 32'h20, 4'h0, 32'h0);
    req0 = 1'b0;
    @(posedge clk); #1;
    chk("byte_merge_model", m0[8], 32'h11BB33DD);

    // Range boundary; 0x1000 would alias word 0 if writes were not blocked.
    issue(0, 1'b1, 32'h0, 4'hF, 32'h01020304);
    issue(0, 1'b1, 32'hFFC, 4'hF, 32'hCAFEF00D);
    issue(0, 1'b0, 32'h1000, 4'hF, 32'h0);
    issue(0, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF);
    issue(0, 1'b0, 32'hFFC, 4'hF, 32'h0);
    issue(0, 1'b0, 32'h0, 4'hF, 32'h0);
    issue(0, 1'b0, 32'h8000_0010, 4'hF, 32'h0);
    req0 = 1'b0;
    @(posedge clk); #1;
    chk("txn0_range", 32'(txn0), 32'(exp0));

    // Reset right after a read grant discards its response.
    issue(0, 1'b0, 32'h10, 4'hF, 32'h0);
    enter_reset();
    @(negedge clk);
    chk("rstd_rvalid0", 32'(rvalid0), 32'd0);
    chk("rstd_gnt0", 32'(gnt0), 32'd0);
    chk("rstd_txn0", 32'(txn0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req0 = 1'b0;
    repeat (2) @(posedge clk); #1;
    issue(0, 1'b0, 32'h10, 4'hF, 32'h0);
    req0 = 1'b0;
    @(posedge clk); #1;
    chk("txn0_after_rst", 32'(txn0), 32'd1);

    // Transaction counter wrap.
    while (exp0 != 16'hFFFF) issue(0, 1'b0, 32'h10, 4'hF, 32'h0);
    chk("txn0_ffff", 32'(txn0), 32'h0000FFFF);
    issue(0, 1'b0, 32'h10, 4'hF, 32'h0);
    chk("txn0_wrap", 32'(txn0), 32'h0);
    req0 = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Stalled slave: back-to-back requests each wait the full stall.
    issue(1, 1'b1, 32'h40, 4'hF, 32'h12345678);
    issue(1, 1'b0, 32'h40, 4'h0, 32'h0);
    req3 = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Withdrawal after one stall cycle.
    we_s = 1'b0; addr_s = 32'h40; req3 = 1'b1;
    @(negedge clk); chk("wd_gnt_a", 32'(gnt3), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("wd_gnt_b", 32'(gnt3), 32'd0);
    @(posedge clk); #1;
    req3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("wd_gnt_c", 32'(gnt3), 32'd0);
    end
    @(posedge clk); #1;
    chk("wd_txn3", 32'(txn3), 32'd2);
    issue(1, 1'b0, 32'h40, 4'hF, 32'h0);
    req3 = 1'b0;
    @(posedge clk); #1;

    // Reset while stalling; next request starts from IDLE, storage survives.
    req3 = 1'b1; we_s = 1'b0; addr_s = 32'h40;
    repeat (2) @(posedge clk); #1;
    enter_reset();
    @(negedge clk);
    chk("rsts_gnt3", 32'(gnt3), 32'd0);
    chk("rsts_txn3", 32'(txn3), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    issue(1, 1'b0, 32'h40, 4'hF, 32'h0);
    req3 = 1'b0;
    issue(0, 1'b0, 32'h20, 4'hF, 32'h0);
    req0 = 1'b0;

    repeat (3) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);
    chk("txn3_final", 32'(txn3), 32'(exp3));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/zeroriscy_dmem_responder.md
ZERORISCY_DMEM_RESPONDER -- requirements
Module: zeroriscy_dmem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, the number of 32-bit words in backing storage (power of two, 4..65536).
REQ-002 SHALL have parameter GNT_STALL, default 0, the number of wait cycles between req assertion and gnt (0..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset; asynchronous and active-high.
REQ-005 SHALL have port data_req_i, input, 1, the initiator request.
REQ-006 SHALL have port data_addr_i, input, 32, the byte address; bits [1:0] ignored.
REQ-007 SHALL have port data_we_i, input, 1, where 1 = write and 0 = read.
REQ-008 SHALL have port data_be_i, input, 4, the byte enables; bit n selects byte lane n.
REQ-009 SHALL have port data_wdata_i, input, 32, the write data.
REQ-010 SHALL have port data_gnt_o, output, 1, the grant; request accepted this cycle.
REQ-011 SHALL have port data_rvalid_o, output, 1, the response valid.
REQ-012 SHALL have port data_rdata_o, output, 32, the read data.
REQ-013 SHALL have port data_err_o, output, 1, the bus error, qualified by data_rvalid_o.
REQ-014 SHALL have port txn_cnt_o, output, 16, the count of granted transactions.

Function
REQ-015 SHALL implement FSM states IDLE and STALL plus a 4-bit stall counter.
REQ-016 IDLE with data_req_i=1 and GNT_STALL=0: SHALL assert data_gnt_o combinationally in the same cycle and remain in IDLE.
REQ-017 IDLE with data_req_i=1 and GNT_STALL>0: SHALL keep data_gnt_o=0, load counter with GNT_STALL-1, and go to STALL.
REQ-018 STALL with data_req_i=1 and counter>0: SHALL decrement counter, data_gnt_o=0.
REQ-019 STALL with data_req_i=1 and counter=0: SHALL assert data_gnt_o in that cycle and return to IDLE; next back-to-back request stalls again for GNT_STALL cycles.
REQ-020 STALL with data_req_i=0 (initiator withdrawal): SHALL return to IDLE, clear counter, no grant, no response.
REQ-021 data_gnt_o SHALL never be 1 while data_req_i=0.
REQ-022 Each grant SHALL produce exactly one data_rvalid_o pulse in the following cycle, for reads and writes alike; with GNT_STALL=0, grants on consecutive cycles SHALL produce rvalid on consecutive cycles.
REQ-023 Word index = data_addr_i[31:2]; an index >= MEM_WORDS SHALL be out of range.
REQ-024 Granted in-range write: SHALL update only byte lanes with data_be_i[n]=1 at the grant edge; response data_err_o=0, data_rdata_o=0.
REQ-025 Granted in-range read: SHALL capture the stored word at the grant edge and present it on data_rdata_o with data_rvalid_o; data_err_o=0; data_be_i does not mask read data.
REQ-026 Granted out-of-range access: SHALL leave storage unchanged; response data_err_o=1, data_rdata_o=0.
REQ-027 Read immediately after write to same word (grant N write, grant N+1 read) SHALL return the newly written data.
REQ-028 When data_rvalid_o=0, data_rdata_o and data_err_o SHALL be 0.
REQ-029 txn_cnt_o SHALL increment by 1 on every grant, including erroring ones, and wrap from 16'hFFFF to 16'h0000.

Reset
REQ-030 While rst=1: FSM in IDLE, counter=0, data_gnt_o=0 (regardless of data_req_i), data_rvalid_o=0, data_rdata_o=0, data_err_o=0, txn_cnt_o=0.
REQ-031 Reset asserted in STALL or with a response pending SHALL discard the pending grant/response; no rvalid after deassertion.
REQ-032 Storage contents SHALL NOT be reset and SHALL survive rst.
REQ-033 First request after rst deasserts SHALL be handled from IDLE with full GNT_STALL delay.

Verification
REQ-034 GNT_STALL=0: write 0xDEADBEEF be=4'hF addr 0x10, then read 0x10 back-to-back -> gnt both cycles, rvalid next two cycles, read rdata=0xDEADBEEF, err=0, txn_cnt_o=2.
REQ-035 Byte enables: write 0x11223344 be=4'hF to 0x20, then 0xAABBCCDD be=4'b0101 -> read 0x20 returns 0x11BB33DD.
REQ-036 GNT_STALL=3: hold req on a read -> gnt exactly 3 cycles after req rise, rvalid 1 cycle later; drop req after 1 stall cycle -> no gnt, no rvalid, txn_cnt_o unchanged.
REQ-037 MEM_WORDS=1024: read addr 0x1000 -> rvalid with err=1, rdata=0; subsequent read 0x0FFC returns last word, err=0.
REQ-038 Assert rst in cycle after a read grant -> no rvalid, txn_cnt_o=0; earlier-written word still readable after reset.
REQ-039 Issue 65536 grants -> txn_cnt_o wraps to 0x0000.
